// File: rtl/arb_pkg.sv
// Shared types and line-geometry helpers for the memory arbiter.
package arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IC_RD,
    DC_RD,
    DC_WR,
    RESP
  } arb_state_e;

  localparam int unsigned LINE_WORDS_DEF = 8;

  // Byte-offset bits covered by one line: word index plus 2 byte-in-word bits.
  function automatic int unsigned line_off_w(input int unsigned words);
    return $clog2(words) + 2;
  endfunction

endpackage

// File: rtl/arb_burst_counter.sv
// Beat counter for one line burst; wraps to zero after the last beat.
module arb_burst_counter
  import arb_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [IDX_W-1:0] o_cnt,
  output logic             o_last
);

  logic [IDX_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= o_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word-wide memory port between I-cache fills
// and D-cache fills/writebacks, one line burst at a time.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ic_req,
  input  logic [ADDR_W-1:0]             ic_addr,
  output logic [DATA_W-1:0]             ic_rdata,
  output logic                          ic_rvalid,
  output logic [$clog2(LINE_WORDS)-1:0] ic_widx,
  output logic                          ic_done,
  input  logic                          dc_req,
  input  logic                          dc_we,
  input  logic [ADDR_W-1:0]             dc_addr,
  input  logic [DATA_W-1:0]             dc_wdata,
  output logic [DATA_W-1:0]             dc_rdata,
  output logic                          dc_rvalid,
  output logic [$clog2(LINE_WORDS)-1:0] dc_widx,
  output logic                          dc_done,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ack,
  output logic                          arb_stall
);

  localparam int unsigned IDX_W      = $clog2(LINE_WORDS);
  localparam int unsigned LINE_OFF_W = line_off_w(LINE_WORDS);
  localparam logic [ADDR_W-1:0] OFF_MASK =
    {{(ADDR_W-LINE_OFF_W){1'b0}}, {LINE_OFF_W{1'b1}}};

  arb_state_e        r_state;
  arb_state_e        w_next;
  logic [ADDR_W-1:0] r_base;
  logic              r_last_dc;
  logic              w_grant_ic;
  logic              w_grant_dc;
  logic              w_burst;
  logic              w_last;
  logic [IDX_W-1:0]  w_cnt;

  assign w_burst = (r_state == IC_RD) || (r_state == DC_RD) || (r_state == DC_WR);

  arb_burst_counter #(
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_grant_ic || w_grant_dc),
    .i_inc  (w_burst && mem_ack),
    .o_cnt  (w_cnt),
    .o_last (w_last)
  );

  // r_last_dc doubles as the owner flag in RESP: it names the last grantee.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_base    <= '0;
      r_last_dc <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant_dc) begin
        r_base    <= dc_addr & ~OFF_MASK;
        r_last_dc <= 1'b1;
      end else if (w_grant_ic) begin
        r_base    <= ic_addr & ~OFF_MASK;
        r_last_dc <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_grant_ic = 1'b0;
    w_grant_dc = 1'b0;
    case (r_state)
      IDLE: begin
        if (dc_req && (!ic_req || !r_last_dc)) begin
          w_grant_dc = 1'b1;
          w_next     = dc_we ? DC_WR : DC_RD;
        end else if (ic_req) begin
          w_grant_ic = 1'b1;
          w_next     = IC_RD;
        end
      end
      IC_RD, DC_RD, DC_WR: begin
        if (mem_ack && w_last) w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = w_burst;
    mem_we    = (r_state == DC_WR);
    mem_addr  = w_burst ? r_base + {{(ADDR_W-IDX_W-2){1'b0}}, w_cnt, 2'b00} : '0;
    mem_wdata = (r_state == DC_WR) ? dc_wdata : '0;

    ic_rvalid = (r_state == IC_RD) && mem_ack;
    ic_rdata  = ((r_state == IC_RD) && mem_ack) ? mem_rdata : '0;
    ic_widx   = (r_state == IC_RD) ? w_cnt : '0;
    ic_done   = (r_state == RESP) && !r_last_dc;

    dc_rvalid = (r_state == DC_RD) && mem_ack;
    dc_rdata  = ((r_state == DC_RD) && mem_ack) ? mem_rdata : '0;
    dc_widx   = ((r_state == DC_RD) || (r_state == DC_WR)) ? w_cnt : '0;
    dc_done   = (r_state == RESP) && r_last_dc;

    arb_stall = (ic_req && !ic_done) || (dc_req && !dc_done);
  end

endmodule
